// File: rtl/framebuffer_cmd_sequencer_pkg.sv
// Shared types and constants for the framebuffer command sequencer.
// Holds the sequencer state encoding and the framebuffer index assignments.
package framebuffer_cmd_sequencer_pkg;

    localparam int NUM_FB_DEFAULT = 3;

    localparam int FB_COLOR   = 0;
    localparam int FB_DEPTH   = 1;
    localparam int FB_STENCIL = 2;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        MEMSET_REQ,
        MEMSET_WAIT,
        COMMIT_SEL,
        COMMIT_REQ,
        COMMIT_WAIT
    } seq_state_e;

    // Width of a framebuffer index; never zero so a single-FB build still has a bit.
    function automatic int fb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/framebuffer_cmd_sequencer_lowest_index.sv
// Combinational priority encoder: reports the lowest set bit of a framebuffer mask.
module fb_lowest_index #(
    parameter int NUM_FB = 3,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_FB-1:0] mask,
    output logic [IDX_W-1:0]  index,
    output logic              found
);

    // Scan downwards so the last hit, the lowest index, wins.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = NUM_FB - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/framebuffer_cmd_sequencer.sv
// Sequences one command: wait for pipeline drain, clear the selected framebuffers in
// parallel, then stream the selected framebuffers out one at a time in ascending order.
module framebuffer_cmd_sequencer
    import framebuffer_cmd_sequencer_pkg::*;
#(
    parameter int NUM_FB              = NUM_FB_DEFAULT,
    parameter int FB_SIZE_IN_PIXEL_LG = 20,
    parameter int ADDR_WIDTH          = 32
) (
    input  logic                           aclk,
    input  logic                           resetn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [NUM_FB-1:0]              cmd_memset_mask,
    input  logic [NUM_FB-1:0]              cmd_commit_mask,
    input  logic [FB_SIZE_IN_PIXEL_LG-1:0] cmd_size,
    input  logic [NUM_FB*ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                           pipe_idle,
    output logic [NUM_FB-1:0]              fb_apply,
    input  logic [NUM_FB-1:0]              fb_applied,
    output logic                           fb_cmd_memset,
    output logic                           fb_cmd_commit,
    output logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_cmd_size,
    output logic [ADDR_WIDTH-1:0]          fb_cmd_addr,
    output logic                           busy
);

    localparam int IDX_W = fb_idx_width(NUM_FB);

    seq_state_e                     state_reg, state_next;
    logic [NUM_FB-1:0]              memset_mask_reg, memset_mask_next;
    logic [NUM_FB-1:0]              commit_mask_reg, commit_mask_next;
    logic [NUM_FB-1:0]              seen_low_reg, seen_low_next;
    logic [FB_SIZE_IN_PIXEL_LG-1:0] size_reg, size_next;
    logic [NUM_FB*ADDR_WIDTH-1:0]   addr_all_reg, addr_all_next;
    logic [ADDR_WIDTH-1:0]          fb_addr_reg, fb_addr_next;
    logic [IDX_W-1:0]               sel_idx_reg, sel_idx_next;

    logic [IDX_W-1:0]      low_idx;
    logic                  low_found;
    logic [NUM_FB-1:0]     low_onehot;
    logic [NUM_FB-1:0]     sel_onehot;
    logic [ADDR_WIDTH-1:0] addr_masked [NUM_FB];
    logic [ADDR_WIDTH-1:0] addr_pick;

    fb_lowest_index #(
        .NUM_FB (NUM_FB),
        .IDX_W  (IDX_W)
    ) u_lowest_index (
        .mask  (commit_mask_reg),
        .index (low_idx),
        .found (low_found)
    );

    for (genvar gi = 0; gi < NUM_FB; gi++) begin : g_fb
        assign low_onehot[gi]  = (low_idx == IDX_W'(gi));
        assign sel_onehot[gi]  = (sel_idx_reg == IDX_W'(gi));
        assign addr_masked[gi] = low_onehot[gi] ? addr_all_reg[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    end

    always_comb begin
        addr_pick = '0;
        for (int i = 0; i < NUM_FB; i++) begin
            addr_pick = addr_pick | addr_masked[i];
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            memset_mask_reg <= '0;
            commit_mask_reg <= '0;
            seen_low_reg    <= '0;
            size_reg        <= '0;
            addr_all_reg    <= '0;
            fb_addr_reg     <= '0;
            sel_idx_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            memset_mask_reg <= memset_mask_next;
            commit_mask_reg <= commit_mask_next;
            seen_low_reg    <= seen_low_next;
            size_reg        <= size_next;
            addr_all_reg    <= addr_all_next;
            fb_addr_reg     <= fb_addr_next;
            sel_idx_reg     <= sel_idx_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        memset_mask_next = memset_mask_reg;
        commit_mask_next = commit_mask_reg;
        seen_low_next    = seen_low_reg;
        size_next        = size_reg;
        addr_all_next    = addr_all_reg;
        fb_addr_next     = fb_addr_reg;
        sel_idx_next     = sel_idx_reg;
        fb_apply         = '0;
        fb_cmd_memset    = 1'b0;
        fb_cmd_commit    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    memset_mask_next = cmd_memset_mask;
                    commit_mask_next = cmd_commit_mask;
                    size_next        = cmd_size;
                    addr_all_next    = cmd_addr;
                    state_next       = DRAIN;
                end
            end
            DRAIN: begin
                seen_low_next = '0;
                if (pipe_idle) begin
                    state_next = (|memset_mask_reg) ? MEMSET_REQ : COMMIT_SEL;
                end
            end
            MEMSET_REQ: begin
                // Framebuffers may drop applied in different cycles, so remember each one.
                fb_apply      = memset_mask_reg;
                fb_cmd_memset = 1'b1;
                seen_low_next = seen_low_reg | (memset_mask_reg & ~fb_applied);
                if (seen_low_next == memset_mask_reg) begin
                    state_next = MEMSET_WAIT;
                end
            end
            MEMSET_WAIT: begin
                if ((fb_applied & memset_mask_reg) == memset_mask_reg) begin
                    state_next = COMMIT_SEL;
                end
            end
            COMMIT_SEL: begin
                if (low_found) begin
                    commit_mask_next = commit_mask_reg & ~low_onehot;
                    fb_addr_next     = addr_pick;
                    sel_idx_next     = low_idx;
                    state_next       = COMMIT_REQ;
                end else begin
                    state_next = IDLE;
                end
            end
            COMMIT_REQ: begin
                fb_apply      = sel_onehot;
                fb_cmd_commit = 1'b1;
                if (!(|(fb_applied & sel_onehot))) begin
                    state_next = COMMIT_WAIT;
                end
            end
            COMMIT_WAIT: begin
                if (|(fb_applied & sel_onehot)) begin
                    state_next = COMMIT_SEL;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign fb_cmd_size = size_reg;
    assign fb_cmd_addr = fb_addr_reg;

endmodule
